// File: rtl/conv_mxi8tobf16.sv
// MXINT block (k signed elements + shared E8M0 scale) to bf16 converter.
// Exact conversion for bit_width <= 8; pipeline depth picked from freq_mhz.
module conv_mxi8tobf16 #(
  parameter int bit_width = 8,
  parameter int k         = 32,
  parameter int freq_mhz  = 100
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [k-1:0][bit_width-1:0]   i_mx_vec,
  input  logic [7:0]                    i_mx_exp,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [k-1:0][15:0]            o_bf16_vec
);

  localparam int lat = (freq_mhz <= 100) ? 1 : (freq_mhz <= 200) ? 2 : 3;

  // Magnitude kept at full bit_width so the most negative code stays exact.
  function automatic logic [bit_width-1:0] abs_val(input logic [bit_width-1:0] m);
    return m[bit_width-1] ? -m : m;
  endfunction

  function automatic logic [2:0] lead_one(input logic [bit_width-1:0] a);
    logic [2:0] p;
    p = '0;
    for (int i = 0; i < bit_width; i++) begin
      if (a[i]) p = 3'(i);
    end
    return p;
  endfunction

  // Builds one bf16 from magnitude, sign, leading-one index and scale.
  function automatic logic [15:0] pack(input logic [bit_width-1:0] a,
                                       input logic s,
                                       input logic [2:0] p,
                                       input logic [7:0] x);
    logic signed [10:0] e;
    logic [7:0]         a8;
    logic [6:0]         mant;
    logic [7:0]         sh;
    a8   = 8'(a);
    e    = 11'(x) + 11'(p) - 11'(bit_width - 2);
    mant = 7'(a8 << (3'd7 - p));
    // Subnormal shift is only meaningful when e <= 0, where it stays below 7.
    sh   = x + 8'(8 - bit_width);
    if (x == 8'hFF)          return 16'h7FC0;
    else if (a == '0)        return 16'h0000;
    else if (e >= 11'sd255)  return {s, 8'hFF, 7'd0};
    else if (e <= 11'sd0)    return {s, 8'd0, 7'(a8 << sh)};
    else                     return {s, e[7:0], mant};
  endfunction

  logic en;
  assign en      = !o_valid || i_ready;
  assign o_ready = en;

  logic [k-1:0][bit_width-1:0] s0_vec;
  logic [7:0]                  s0_exp;
  logic                        s0_valid;

  if (lat == 3) begin : g_in_reg
    // Optional input register for the fastest clock targets.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        s0_valid <= 1'b0;
        s0_vec   <= '0;
        s0_exp   <= '0;
      end else if (en) begin
        s0_valid <= i_valid;
        if (i_valid) begin
          s0_vec <= i_mx_vec;
          s0_exp <= i_mx_exp;
        end
      end
    end
  end else begin : g_in_bypass
    assign s0_valid = i_valid;
    assign s0_vec   = i_mx_vec;
    assign s0_exp   = i_mx_exp;
  end

  logic [k-1:0][bit_width-1:0] d_abs;
  logic [k-1:0]                d_sign;
  logic [k-1:0][2:0]           d_p;

  // Per-element magnitude, sign and leading-one position.
  always_comb begin
    for (int i = 0; i < k; i++) begin
      d_abs[i]  = abs_val(s0_vec[i]);
      d_sign[i] = s0_vec[i][bit_width-1];
      d_p[i]    = lead_one(d_abs[i]);
    end
  end

  logic [k-1:0][bit_width-1:0] s1_abs;
  logic [k-1:0]                s1_sign;
  logic [k-1:0][2:0]           s1_p;
  logic [7:0]                  s1_exp;
  logic                        s1_valid;

  if (lat >= 2) begin : g_mid_reg
    // Split point between magnitude/LZC and exponent/pack.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        s1_valid <= 1'b0;
        s1_abs   <= '0;
        s1_sign  <= '0;
        s1_p     <= '0;
        s1_exp   <= '0;
      end else if (en) begin
        s1_valid <= s0_valid;
        if (s0_valid) begin
          s1_abs  <= d_abs;
          s1_sign <= d_sign;
          s1_p    <= d_p;
          s1_exp  <= s0_exp;
        end
      end
    end
  end else begin : g_mid_bypass
    assign s1_valid = s0_valid;
    assign s1_abs   = d_abs;
    assign s1_sign  = d_sign;
    assign s1_p     = d_p;
    assign s1_exp   = s0_exp;
  end

  // Output register: pack and hold while downstream stalls.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid    <= 1'b0;
      o_bf16_vec <= '0;
    end else if (en) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        for (int i = 0; i < k; i++) begin
          o_bf16_vec[i] <= pack(s1_abs[i], s1_sign[i], s1_p[i], s1_exp);
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_mxi8tobf16.sv
// Directed bench for conv_mxi8tobf16: three instances at L=1/2/3.
module tb_conv_mxi8tobf16;

  logic                   clk;
  logic                   rst_n;
  logic [2:0]             valid_in;
  logic [2:0]             ready_in;
  logic [2:0][31:0][7:0]  vec_in;
  logic [2:0][7:0]        exp_in;
  logic [2:0]             ordy;
  logic [2:0]             ovld;
  logic [2:0][31:0][15:0] obf;

  int compared;
  int mismatched;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    conv_mxi8tobf16 #(
      .bit_width(8),
      .k(32),
      .freq_mhz(g == 0 ? 100 : (g == 1 ? 200 : 400))
    ) u_dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .i_valid(valid_in[g]),
      .o_ready(ordy[g]),
      .i_mx_vec(vec_in[g]),
      .i_mx_exp(exp_in[g]),
      .o_valid(ovld[g]),
      .i_ready(ready_in[g]),
      .o_bf16_vec(obf[g])
    );
  end

  always #5 clk = ~clk;

  // Drives one block with i_ready high and waits (bounded) for its output.
  task automatic run_block(input int d, input logic [31:0][7:0] v, input logic [7:0] x,
                           output logic [31:0][15:0] res, output int lat);
    @(negedge clk);
    ready_in[d] = 1'b1;
    valid_in[d] = 1'b1;
    vec_in[d]   = v;
    exp_in[d]   = x;
    @(posedge clk);
    @(negedge clk);
    valid_in[d] = 1'b0;
    lat = -1;
    res = '0;
    for (int c = 1; c <= 8; c++) begin
      if (ovld[d]) begin
        lat = c;
        res = obf[d];
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [31:0][7:0]  v;
    logic [31:0][15:0] res;
    int lat;
    #12;
    for (int d = 0; d < 3; d++) begin
      compared++;
      if (ovld[d] !== 1'b0) begin mismatched++; $display("FAIL reset_valid d=%0d got %b want 0", d, ovld[d]); end
      compared++;
      if (ordy[d] !== 1'b1) begin mismatched++; $display("FAIL reset_ready d=%0d got %b want 1", d, ordy[d]); end
      compared++;
      if (obf[d] !== '0) begin mismatched++; $display("FAIL reset_data d=%0d got %h want 0", d, obf[d]); end
    end
    ready_in = '1;
    @(negedge clk);
    rst_n = 1'b1;
    // Fill the L=3 pipe with three blocks, then reset with two still inside.
    for (int j = 0; j < 32; j++) v[j] = 8'd64;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      valid_in[2] = 1'b1;
      vec_in[2]   = v;
      exp_in[2]   = 8'd127;
      @(posedge clk);
    end
    @(negedge clk);
    valid_in[2] = 1'b0;
    compared++;
    if (ovld[2] !== 1'b1 || obf[2][0] !== 16'h3F80) begin
      mismatched++; $display("FAIL midstream_out got v=%b %h want v=1 3f80", ovld[2], obf[2][0]);
    end
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if (ovld[2] !== 1'b0) begin mismatched++; $display("FAIL async_reset_valid got %b want 0", ovld[2]); end
    compared++;
    if (obf[2] !== '0) begin mismatched++; $display("FAIL async_reset_data got %h want 0", obf[2]); end
    @(posedge clk);
    #1;
    compared++;
    if (ordy[2] !== 1'b1) begin mismatched++; $display("FAIL reset_ready_held got %b want 1", ordy[2]); end
    @(negedge clk);
    rst_n = 1'b1;
    v = '0;
    v[0] = 8'd1;
    run_block(2, v, 8'd127, res, lat);
    compared++;
    if (lat !== 3) begin mismatched++; $display("FAIL post_reset_latency got %0d want 3", lat); end
    compared++;
    if (res[0] !== 16'h3C80 || res[1] !== 16'h0000) begin
      mismatched++; $display("FAIL post_reset_data got %h %h want 3c80 0000", res[0], res[1]);
    end
  endtask

  task automatic test_normal();
    logic [31:0][7:0]  v;
    logic [31:0][15:0] res;
    logic [15:0]       want [5];
    int lat;
    v = '0;
    v[0] = 8'd64; v[1] = 8'h80; v[2] = 8'd1; v[3] = 8'd0; v[4] = 8'd127;
    want = '{16'h3F80, 16'hC000, 16'h3C80, 16'h0000, 16'h3FFE};
    for (int d = 0; d < 2; d++) begin
      run_block(d, v, 8'd127, res, lat);
      compared++;
      if (lat !== d + 1) begin mismatched++; $display("FAIL normal_latency d=%0d got %0d want %0d", d, lat, d + 1); end
      for (int j = 0; j < 5; j++) begin
        compared++;
        if (res[j] !== want[j]) begin
          mismatched++; $display("FAIL normal[%0d] d=%0d got %h want %h", j, d, res[j], want[j]);
        end
      end
      compared++;
      if (res[31] !== 16'h0000) begin mismatched++; $display("FAIL normal_zero_tail d=%0d got %h want 0000", d, res[31]); end
    end
  endtask

  task automatic test_subnormal_overflow();
    logic [31:0][7:0]  v;
    logic [31:0][15:0] res;
    logic [7:0]        sc  [4];
    logic [7:0]        el  [4];
    logic [15:0]       want [4];
    int lat;
    sc   = '{8'd0,    8'd1,    8'd254,  8'd254};
    el   = '{8'd1,    8'hFD,   8'h80,   8'd127};
    want = '{16'h0001, 16'h8006, 16'hFF80, 16'h7F7E};
    for (int t = 0; t < 4; t++) begin
      v = '0;
      v[0] = el[t];
      run_block(0, v, sc[t], res, lat);
      compared++;
      if (lat !== 1 || res[0] !== want[t]) begin
        mismatched++; $display("FAIL edge_case[%0d] got lat=%0d %h want lat=1 %h", t, lat, res[0], want[t]);
      end
    end
  endtask

  task automatic test_nan();
    logic [31:0][7:0]  v;
    logic [31:0][15:0] res;
    int lat;
    for (int j = 0; j < 32; j++) v[j] = 8'($urandom);
    run_block(2, v, 8'hFF, res, lat);
    compared++;
    if (lat !== 3) begin mismatched++; $display("FAIL nan_latency got %0d want 3", lat); end
    for (int j = 0; j < 32; j++) begin
      compared++;
      if (res[j] !== 16'h7FC0) begin mismatched++; $display("FAIL nan[%0d] got %h want 7fc0", j, res[j]); end
    end
  endtask

  task automatic test_back_pressure(input int d);
    logic [15:0]       tbl [8];
    logic [31:0][15:0] want;
    logic [31:0][15:0] held;
    logic [31:0][7:0]  v;
    logic              rdy;
    logic              extra;
    int in_idx;
    int out_idx;
    tbl = '{16'h3C80, 16'h3D00, 16'h3D40, 16'h3D80, 16'h3DA0, 16'h3DC0, 16'h3DE0, 16'h3E00};
    in_idx = 0;
    out_idx = 0;
    held = '0;
    for (int c = 0; c < 40 && out_idx < 8; c++) begin
      @(negedge clk);
      rdy = !(c >= 4 && c <= 6);
      ready_in[d] = rdy;
      #1;
      if (!rdy) begin
        compared++;
        if (ovld[d] !== 1'b1 || ordy[d] !== 1'b0) begin
          mismatched++; $display("FAIL stall_flags d=%0d c=%0d got v=%b r=%b want v=1 r=0", d, c, ovld[d], ordy[d]);
        end
        if (c == 4) held = obf[d];
        else begin
          compared++;
          if (obf[d] !== held) begin mismatched++; $display("FAIL stall_hold d=%0d c=%0d got %h want %h", d, c, obf[d][0], held[0]); end
        end
      end
      if (ovld[d] && rdy) begin
        want = '0;
        want[0] = tbl[out_idx];
        want[1] = tbl[out_idx] | 16'h8000;
        compared++;
        if (obf[d] !== want) begin
          mismatched++; $display("FAIL bp_order d=%0d blk=%0d got %h %h want %h %h", d, out_idx, obf[d][0], obf[d][1], want[0], want[1]);
        end
        out_idx++;
      end
      if (in_idx < 8) begin
        v = '0;
        v[0] = 8'(in_idx + 1);
        v[1] = 8'(-(in_idx + 1));
        valid_in[d] = 1'b1;
        vec_in[d]   = v;
        exp_in[d]   = 8'd127;
        if (ordy[d]) in_idx++;
      end else begin
        valid_in[d] = 1'b0;
      end
    end
    valid_in[d] = 1'b0;
    ready_in[d] = 1'b1;
    compared++;
    if (out_idx !== 8) begin mismatched++; $display("FAIL bp_count d=%0d got %0d want 8", d, out_idx); end
    extra = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (ovld[d]) extra = 1'b1;
    end
    compared++;
    if (extra !== 1'b0) begin mismatched++; $display("FAIL bp_duplicate d=%0d got extra output want none", d); end
  endtask

  initial begin
    clk        = 1'b0;
    rst_n      = 1'b0;
    valid_in   = '0;
    ready_in   = '0;
    vec_in     = '0;
    exp_in     = '0;
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_normal();
    test_subnormal_overflow();
    test_nan();
    for (int d = 0; d < 3; d++) test_back_pressure(d);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
